// File: rtl/lbp_hist.sv
// 256-bin histogram of LBP codes with a 3-stage read-modify-write accumulate pipeline.
// When the frame completes, the bin counts are streamed out over a valid/ready interface.
module lbp_hist #(
  parameter int CNT_W      = 14,
  parameter int EXP_PIXELS = 15876
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lbp_valid,
  input  logic [13:0]      lbp_addr,
  input  logic [7:0]       lbp_data,
  input  logic             finish,
  input  logic             start,
  input  logic             hist_ready,
  output logic             hist_valid,
  output logic [7:0]       hist_bin,
  output logic [CNT_W-1:0] hist_count,
  output logic             done,
  output logic             cnt_err,
  output logic             late_err
);

  typedef enum logic [2:0] {ACC, DRAIN, OUT_RD, OUT_VLD, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [13:0]      PIX_MAX = '1;
  localparam logic [13:0]      PIX_EXP = 14'(EXP_PIXELS);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] mem [256];
  logic [255:0]     bin_vld;
  logic             s1_valid, s2_valid, s2_fwd;
  logic [7:0]       s1_bin, s2_bin, rd_addr, ptr;
  logic [CNT_W-1:0] s2_fwd_val, rd_q, s2_old, s2_new;
  logic [13:0]      pix_cnt, pix_nxt;
  logic             drain_cnt, accept, restart;
  logic             addr_unused;

  assign addr_unused = ^lbp_addr;
  assign accept      = lbp_valid && (state == ACC);
  assign restart     = (state == DONE) && start;

  always_comb begin
    state_nxt = state;
    case (state)
      ACC:     if (finish) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt) state_nxt = OUT_RD;
      OUT_RD:  state_nxt = OUT_VLD;
      OUT_VLD: if (hist_ready) state_nxt = (ptr == 8'd255) ? DONE : OUT_RD;
      DONE:    if (start) state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ACC;
      drain_cnt <= 1'b0;
      ptr       <= 8'd0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
      if (state == OUT_VLD && hist_ready) ptr <= ptr + 8'd1;
    end
  end

  // One shared read port: the pipeline owns it while accumulating, the output stream afterwards.
  assign rd_addr = (state == ACC || state == DRAIN) ? s1_bin : ptr;
  assign s2_old  = s2_fwd ? s2_fwd_val : rd_q;
  assign s2_new  = (s2_old == CNT_MAX) ? CNT_MAX : s2_old + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_bin     <= 8'd0;
      s2_valid   <= 1'b0;
      s2_bin     <= 8'd0;
      s2_fwd     <= 1'b0;
      s2_fwd_val <= '0;
      rd_q       <= '0;
    end else begin
      s1_valid   <= accept;
      if (accept) s1_bin <= lbp_data;
      s2_valid   <= s1_valid;
      s2_bin     <= s1_bin;
      s2_fwd     <= s1_valid && s2_valid && (s1_bin == s2_bin);
      s2_fwd_val <= s2_new;
      rd_q       <= bin_vld[rd_addr] ? mem[rd_addr] : '0;
    end
  end

  // Count storage carries no reset; the valid bits alone decide whether a bin reads as zero.
  always_ff @(posedge clk) begin
    if (s2_valid) mem[s2_bin] <= s2_new;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) bin_vld <= '0;
    else if (restart) bin_vld <= '0;
    else if (s2_valid) bin_vld[s2_bin] <= 1'b1;
  end

  assign pix_nxt = (accept && pix_cnt != PIX_MAX) ? pix_cnt + 14'd1 : pix_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_cnt  <= 14'd0;
      cnt_err  <= 1'b0;
      late_err <= 1'b0;
    end else if (restart) begin
      pix_cnt  <= 14'd0;
      cnt_err  <= 1'b0;
      late_err <= 1'b0;
    end else begin
      pix_cnt <= pix_nxt;
      if (state == ACC && finish && pix_nxt != PIX_EXP) cnt_err <= 1'b1;
      if (lbp_valid && state != ACC) late_err <= 1'b1;
    end
  end

  assign hist_valid = (state == OUT_VLD);
  assign hist_bin   = ptr;
  assign hist_count = hist_valid ? rd_q : '0;
  assign done       = (state == DONE);

endmodule

// File: tb/tb_lbp_hist.sv
// Randomized scoreboard bench for lbp_hist: a full-width and a 4-bit-count instance share the stimulus.
// A per-frame bin-count model queues the expected stream; a negedge monitor pops and compares.
module tb_lbp_hist;

  typedef struct {
    int bin;
    int count;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        lbp_valid = 1'b0;
  logic [13:0] lbp_addr = 14'd0;
  logic [7:0]  lbp_data = 8'd0;
  logic        finish = 1'b0;
  logic        start = 1'b0;
  logic        hist_ready = 1'b1;

  logic        hv_a, done_a, ce_a, le_a;
  logic [7:0]  hb_a;
  logic [13:0] hc_a;
  logic        hv_b, done_b, ce_b, le_b;
  logic [7:0]  hb_b;
  logic [3:0]  hc_b;

  exp_t exp_q[$];
  exp_t e;
  int   compared = 0;
  int   mismatched = 0;
  int   model_hist[256];
  int   model_pix;
  bit   model_acc, model_late, model_cnt_err;
  bit   ready_rand = 1'b0;
  bit   stall_bin3 = 1'b0;
  int   stall_cnt = 0;
  bit   stalled = 1'b0;
  int   prev_bin, prev_cnt;

  lbp_hist dut_a (
    .clk(clk), .reset(reset), .lbp_valid(lbp_valid), .lbp_addr(lbp_addr),
    .lbp_data(lbp_data), .finish(finish), .start(start), .hist_ready(hist_ready),
    .hist_valid(hv_a), .hist_bin(hb_a), .hist_count(hc_a), .done(done_a),
    .cnt_err(ce_a), .late_err(le_a)
  );

  lbp_hist #(.CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .lbp_valid(lbp_valid), .lbp_addr(lbp_addr),
    .lbp_data(lbp_data), .finish(finish), .start(start), .hist_ready(hist_ready),
    .hist_valid(hv_b), .hist_bin(hb_b), .hist_count(hc_b), .done(done_b),
    .cnt_err(ce_b), .late_err(le_b)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic model_clear();
    model_acc     = 1'b1;
    model_late    = 1'b0;
    model_cnt_err = 1'b0;
    model_pix     = 0;
    for (int b = 0; b < 256; b++) model_hist[b] = 0;
  endtask

  // Drive one cycle of engine traffic and update the frame model from the rules directly.
  task automatic applyStimulus(input bit v, input int d, input bit fin);
    lbp_valid = v;
    lbp_data  = 8'(d);
    lbp_addr  = 14'($urandom);
    finish    = fin;
    if (v) begin
      if (model_acc) begin
        model_hist[d]++;
        model_pix++;
      end else begin
        model_late = 1'b1;
      end
    end
    if (fin && model_acc) begin
      model_acc     = 1'b0;
      model_cnt_err = (model_pix != 15876);
      for (int b = 0; b < 256; b++) exp_q.push_back('{b, model_hist[b]});
    end
    @(posedge clk); #1;
    lbp_valid = 1'b0;
    finish    = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model_clear();
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done_a && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput({tag, "_done"}, int'(done_a), 1);
    checkOutput({tag, "_done_b"}, int'(done_b), 1);
    checkOutput({tag, "_hist_valid"}, int'(hv_a), 0);
    checkOutput({tag, "_cnt_err"}, int'(ce_a), int'(model_cnt_err));
    checkOutput({tag, "_late_err"}, int'(le_a), int'(model_late));
    checkOutput({tag, "_cnt_err_b"}, int'(ce_b), int'(model_cnt_err));
    checkOutput({tag, "_bins_left"}, exp_q.size(), 0);
  endtask

  always @(posedge clk) begin
    #1;
    if (stall_bin3 && hv_a && hb_a == 8'd3 && stall_cnt < 10) begin
      hist_ready = 1'b0;
      stall_cnt++;
    end else begin
      hist_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        checkOutput("hold_valid", int'(hv_a), 1);
        checkOutput("hold_bin", int'(hb_a), prev_bin);
        checkOutput("hold_count", int'(hc_a), prev_cnt);
      end
      if (hv_a && hist_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("extra_bin_queue", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          checkOutput("bin", int'(hb_a), e.bin);
          checkOutput("count", int'(hc_a), e.count);
          checkOutput("valid_b", int'(hv_b), 1);
          checkOutput("bin_b", int'(hb_b), e.bin);
          checkOutput("count_b", int'(hc_b), (e.count > 15) ? 15 : e.count);
        end
      end
      stalled  = hv_a && !hist_ready;
      prev_bin = int'(hb_a);
      prev_cnt = int'(hc_a);
    end
  end

  initial begin
    int n;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_hist_valid", int'(hv_a), 0);
    checkOutput("rst_hist_bin", int'(hb_a), 0);
    checkOutput("rst_hist_count", int'(hc_a), 0);
    checkOutput("rst_done", int'(done_a), 0);
    checkOutput("rst_cnt_err", int'(ce_a), 0);
    checkOutput("rst_late_err", int'(le_a), 0);
    reset = 1'b0;

    // Full frame of code 0, then a stalled bin 3 and the first-bin latency.
    ready_rand = 1'b1;
    stall_bin3 = 1'b1;
    for (int i = 0; i < 15876; i++) applyStimulus(1'b1, 0, 1'b0);
    applyStimulus(1'b0, 0, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    checkOutput("latency_before", int'(hv_a), 0);
    @(posedge clk); #1;
    checkOutput("latency_first", int'(hv_a), 1);
    wait_done("frameA");
    checkOutput("stall_cycles", stall_cnt, 10);
    stall_bin3 = 1'b0;

    // Forwarding hazard, code with finish counted, late code dropped.
    do_start();
    applyStimulus(1'b1, 5, 1'b0);
    applyStimulus(1'b1, 5, 1'b0);
    applyStimulus(1'b1, 5, 1'b0);
    applyStimulus(1'b1, 7, 1'b0);
    applyStimulus(1'b1, 5, 1'b1);
    applyStimulus(1'b1, 9, 1'b0);
    wait_done("frameB");

    // Random dense traffic on a few hot bins plus a start pulse that must be ignored.
    do_start();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) start = 1'b1;
      applyStimulus(1'($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(40, 43)),
                    1'b0);
      start = 1'b0;
    end
    applyStimulus(1'b0, 0, 1'b1);
    wait_done("frameC");

    // Reset in the middle of the output stream.
    do_start();
    for (int i = 0; i < 200; i++) applyStimulus(1'b1, int'($urandom_range(0, 31)), 1'b0);
    applyStimulus(1'b0, 0, 1'b1);
    n = 0;
    while (!(hv_a && hb_a >= 8'd10) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("reach_stream", int'(hv_a), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_hist_valid", int'(hv_a), 0);
    checkOutput("abort_done", int'(done_a), 0);
    checkOutput("abort_hist_count", int'(hc_a), 0);
    exp_q.delete();
    model_clear();
    reset = 1'b0;

    // Frame after reset: previous counts must be gone.
    for (int i = 0; i < 49; i++) applyStimulus(1'b1, int'($urandom_range(0, 63)), 1'b0);
    applyStimulus(1'b1, 63, 1'b1);
    wait_done("frameE");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
